// File: rtl/alu_exec_unit.sv
// Execute-stage ALU: single-cycle logic/arithmetic ops, iterative one-bit-per-cycle
// shifts, valid/ready handshakes on request and result sides.
module alu_exec_unit #(
   parameter int WIDTH = 32,
   parameter int SHW   = 5
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [3:0]       alu_ctrl,
   input  logic [WIDTH-1:0] op_a,
   input  logic [WIDTH-1:0] op_b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             zero,
   output logic             illegal
);

   localparam logic [3:0] CTRL_AND = 4'b0000;
   localparam logic [3:0] CTRL_OR  = 4'b0001;
   localparam logic [3:0] CTRL_ADD = 4'b0010;
   localparam logic [3:0] CTRL_XOR = 4'b0011;
   localparam logic [3:0] CTRL_SLL = 4'b0100;
   localparam logic [3:0] CTRL_SRL = 4'b0101;
   localparam logic [3:0] CTRL_SUB = 4'b0110;
   localparam logic [3:0] CTRL_SLT = 4'b0111;
   localparam logic [3:0] CTRL_SRA = 4'b1101;

   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
   typedef enum logic [1:0] {SH_LL, SH_RL, SH_RA} shift_t;

   state_t           state;
   shift_t           shift_type;
   logic [WIDTH-1:0] work;
   logic [SHW-1:0]   count;

   logic [WIDTH-1:0] alu_value;
   logic             is_shift;
   logic             is_legal;
   shift_t           shift_kind;
   logic [SHW-1:0]   shamt;
   logic [WIDTH-1:0] work_next;

   assign shamt     = op_b[SHW-1:0];
   assign in_ready  = (state == IDLE);
   assign out_valid = (state == DONE);
   assign zero      = (result == '0);

   // Decode the request: one-cycle value, or shift flavour to hand to the iterator.
   always_comb begin
      alu_value  = '0;
      is_shift   = 1'b0;
      is_legal   = 1'b1;
      shift_kind = SH_LL;
      case (alu_ctrl)
         CTRL_AND: alu_value = op_a & op_b;
         CTRL_OR:  alu_value = op_a | op_b;
         CTRL_ADD: alu_value = op_a + op_b;
         CTRL_SUB: alu_value = op_a - op_b;
         CTRL_XOR: alu_value = op_a ^ op_b;
         CTRL_SLT: alu_value = {{(WIDTH-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
         CTRL_SLL: begin is_shift = 1'b1; shift_kind = SH_LL; end
         CTRL_SRL: begin is_shift = 1'b1; shift_kind = SH_RL; end
         CTRL_SRA: begin is_shift = 1'b1; shift_kind = SH_RA; end
         default:  is_legal = 1'b0;
      endcase
   end

   always_comb begin
      work_next = work;
      case (shift_type)
         SH_LL:   work_next = {work[WIDTH-2:0], 1'b0};
         SH_RL:   work_next = {1'b0, work[WIDTH-1:1]};
         SH_RA:   work_next = {work[WIDTH-1], work[WIDTH-1:1]};
         default: work_next = work;
      endcase
   end

   // The last shift step writes straight into result so DONE follows immediately.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= IDLE;
         result     <= '0;
         illegal    <= 1'b0;
         work       <= '0;
         count      <= '0;
         shift_type <= SH_LL;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  if (!is_legal) begin
                     result  <= '0;
                     illegal <= 1'b1;
                     state   <= DONE;
                  end else if (is_shift) begin
                     illegal <= 1'b0;
                     if (shamt == '0) begin
                        result <= op_a;
                        state  <= DONE;
                     end else begin
                        work       <= op_a;
                        count      <= shamt;
                        shift_type <= shift_kind;
                        state      <= SHIFT;
                     end
                  end else begin
                     result  <= alu_value;
                     illegal <= 1'b0;
                     state   <= DONE;
                  end
               end
            end
            SHIFT: begin
               work  <= work_next;
               count <= count - 1'b1;
               if (count == SHW'(1)) begin
                  result <= work_next;
                  state  <= DONE;
               end
            end
            DONE: begin
               if (out_ready) begin
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
